// File: rtl/cpu_pkg.sv
// Shared CPU-side constants for the interrupt path.
// Holds the interrupt FSM state encoding, the source index assignments and the
// default handler vector addresses used by irq_controller and its users.
package cpu_pkg;

   // Interrupt controller FSM state encoding
   typedef logic [1:0] irq_state_t;
   localparam irq_state_t IRQ_IDLE    = 2'd0;
   localparam irq_state_t IRQ_REQ     = 2'd1;
   localparam irq_state_t IRQ_SERVICE = 2'd2;

   // Source indices; a lower index has the higher priority
   localparam int unsigned SRC_EXT = 0;
   localparam int unsigned SRC_T0  = 1;
   localparam int unsigned SRC_T1  = 2;

   // Default handler vectors (VEC_BASE + idx * VEC_STRIDE)
   localparam logic [9:0] VEC_EXT = 10'h010;
   localparam logic [9:0] VEC_T0  = 10'h020;
   localparam logic [9:0] VEC_T1  = 10'h030;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: reports the lowest set bit of req_i.
// Ports:
//   req_i   - request vector, bit 0 has the highest priority
//   idx_o   - index of the lowest set bit (0 when nothing is set)
//   valid_o - at least one request bit is set
module irq_prio_enc #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // Scan from the top so the lowest set index is the last one written
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = IDX_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Prioritising interrupt arbiter between the interrupt sources and the CPU
// sequencer. Latches requests, masks them with the global/per-source enables,
// picks the lowest-index winner and runs a request/grant/return handshake.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   src_req_i     - raw source requests (edge or level per EDGE_MASK)
//   src_en_i      - per-source enables
//   gie_i         - global interrupt enable
//   irq_grant_i   - CPU accepts the pending interrupt (1-cycle pulse)
//   irq_reti_i    - CPU finished the handler (1-cycle pulse)
//   ovr_clr_i     - clear the matching overrun flags
//   irq_req_o     - interrupt pending toward the CPU
//   irq_vector_o  - handler address of the selected source
//   src_ack_o     - 1-cycle acknowledge to the granted source
//   active_id_o   - index of the selected or in-service source
//   in_service_o  - a handler is running
//   overrun_o     - sticky: edge arrived while that source was already pending
module irq_controller
   import cpu_pkg::*;
#(
   parameter int unsigned             NUM_SRC    = 3,
   parameter int unsigned             ADDR_W     = 10,
   parameter logic [ADDR_W-1:0]       VEC_BASE   = 10'h010,
   parameter logic [ADDR_W-1:0]       VEC_STRIDE = 10'h010,
   parameter logic [NUM_SRC-1:0]      EDGE_MASK  = 3'b001
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  src_req_i,
   input  logic [NUM_SRC-1:0]  src_en_i,
   input  logic                gie_i,
   input  logic                irq_grant_i,
   input  logic                irq_reti_i,
   input  logic [NUM_SRC-1:0]  ovr_clr_i,
   output logic                irq_req_o,
   output logic [ADDR_W-1:0]   irq_vector_o,
   output logic [NUM_SRC-1:0]  src_ack_o,
   output logic [1:0]          active_id_o,
   output logic                in_service_o,
   output logic [NUM_SRC-1:0]  overrun_o
);

   irq_state_t          state_q, state_d;
   logic [NUM_SRC-1:0]  prev_q;
   logic [NUM_SRC-1:0]  pend_q, pend_d;
   logic [NUM_SRC-1:0]  ovr_q, ovr_d;
   logic [NUM_SRC-1:0]  ack_q, ack_d;
   logic [1:0]          sel_q, sel_d;
   logic [ADDR_W-1:0]   vec_q, vec_d;
   logic                irq_req_q, irq_req_d;
   logic                in_svc_q, in_svc_d;

   logic [NUM_SRC-1:0]  rise;
   logic [NUM_SRC-1:0]  pending;
   logic [NUM_SRC-1:0]  eligible;
   logic [NUM_SRC-1:0]  grant_clr;
   logic [1:0]          win_idx;
   logic                win_valid;

   // Only edge-latched sources ever see a rise; level sources bypass the latch
   assign rise     = src_req_i & ~prev_q & EDGE_MASK;
   assign pending  = (pend_q & EDGE_MASK) | (src_req_i & ~EDGE_MASK);
   assign eligible = pending & src_en_i & {NUM_SRC{gie_i}};

   irq_prio_enc #(
      .N     (NUM_SRC),
      .IDX_W (2)
   ) u_prio_enc (
      .req_i   (eligible),
      .idx_o   (win_idx),
      .valid_o (win_valid)
   );

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      vec_d     = vec_q;
      irq_req_d = 1'b0;
      in_svc_d  = in_svc_q;
      ack_d     = '0;
      grant_clr = '0;
      case (state_q)
         IRQ_IDLE: begin
            if (win_valid) begin
               sel_d     = win_idx;
               vec_d     = VEC_BASE + VEC_STRIDE * ADDR_W'(win_idx);
               irq_req_d = 1'b1;
               state_d   = IRQ_REQ;
            end
         end
         IRQ_REQ: begin
            // Grant beats a simultaneous withdraw; sel stays frozen here
            if (irq_grant_i) begin
               ack_d     = NUM_SRC'(1) << sel_q;
               grant_clr = NUM_SRC'(1) << sel_q;
               in_svc_d  = 1'b1;
               state_d   = IRQ_SERVICE;
            end else if (!eligible[sel_q]) begin
               state_d = IRQ_IDLE;
            end else begin
               irq_req_d = 1'b1;
            end
         end
         IRQ_SERVICE: begin
            if (irq_reti_i) begin
               in_svc_d = 1'b0;
               state_d  = IRQ_IDLE;
            end
         end
         default: begin
            state_d  = IRQ_IDLE;
            in_svc_d = 1'b0;
         end
      endcase
   end

   // A new edge beats the grant clear and the overrun clear
   assign pend_d = (pend_q & ~grant_clr) | rise;
   assign ovr_d  = (ovr_q & ~ovr_clr_i) | (rise & pend_q);

   always_ff @(posedge clk) begin
      // History loads during reset too, so a level high at release is no edge
      prev_q <= src_req_i;
      if (rst) begin
         state_q   <= IRQ_IDLE;
         pend_q    <= '0;
         ovr_q     <= '0;
         ack_q     <= '0;
         sel_q     <= '0;
         vec_q     <= '0;
         irq_req_q <= 1'b0;
         in_svc_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         ovr_q     <= ovr_d;
         ack_q     <= ack_d;
         sel_q     <= sel_d;
         vec_q     <= vec_d;
         irq_req_q <= irq_req_d;
         in_svc_q  <= in_svc_d;
      end
   end

   assign irq_req_o    = irq_req_q;
   assign irq_vector_o = vec_q;
   assign src_ack_o    = ack_q;
   assign active_id_o  = sel_q;
   assign in_service_o = in_svc_q;
   assign overrun_o    = ovr_q;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Prioritising interrupt arbiter placed between the interrupt sources (external pin, timer 0, timer 1) and the CPU sequencer. It latches requests, masks them with the global and per-source enables, picks one winner, and runs a request/grant handshake with the CPU at instruction boundaries. It returns the vector address and pulses the winning source's acknowledge, then blocks further interrupts until the CPU signals return-from-interrupt. Nesting is not supported.

Parameters:
NUM_SRC, 3, number of interrupt sources; index 0 has the highest priority.
ADDR_W, 10, width of the program-address vector.
VEC_BASE, 10'h010, vector for source 0.
VEC_STRIDE, 10'h010, address step between consecutive source vectors.
EDGE_MASK, 3'b001, bit i=1: source i is rising-edge latched; bit i=0: source i is level, held by the source until src_ack.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
src_req  in  NUM_SRC  raw requests (ext_int, timer0 done, timer1 done); synchronous to clk
src_en  in  NUM_SRC  per-source enable (CPU config bits)
gie  in  1  global interrupt enable
irq_grant  in  1  CPU accepts the interrupt at an instruction boundary; 1-cycle pulse
irq_reti  in  1  CPU finished the handler; 1-cycle pulse
ovr_clr  in  NUM_SRC  clear the matching overrun flags
irq_req  out  1  interrupt pending toward the CPU
irq_vector  out  ADDR_W  handler address of the selected source
src_ack  out  NUM_SRC  1-cycle acknowledge to the granted source
active_id  out  2  index of the selected or in-service source
in_service  out  1  a handler is running
overrun  out  NUM_SRC  sticky: an edge arrived while that source was already pending

Behaviour:
- Reset: all outputs are 0, pending is 0, state is IDLE. The edge-detect history register loads src_req during reset, so an input already high at reset release is not an edge.
- Pending, edge source: set on a rising edge (src_req & ~prev); cleared on the grant of that source. If a new edge and the clear land in the same cycle, the set wins and the edge counts as a new event.
- Pending, level source: pending = src_req, with no latch.
- Overrun: overrun[i] is set when an edge arrives while pending[i] is already 1. It is cleared by ovr_clr[i]. If set and clear coincide, the set wins.
- eligible = pending & src_en, gated by gie. The winner is the lowest set index.
- State IDLE: if eligible is non-zero, register sel = winner, active_id = sel, irq_vector = VEC_BASE + sel*VEC_STRIDE (truncated to ADDR_W), and go to REQ. irq_req rises 1 cycle after the eligible request is seen.
- State REQ: irq_req = 1. sel is frozen; a higher-priority arrival does not re-arbitrate.
  - Withdraw: if gie drops or eligible[sel] drops, clear irq_req and go to IDLE next cycle.
  - Grant: on irq_grant (with no withdraw in the same cycle), in the next cycle src_ack[sel] = 1 for exactly 1 cycle, the pending bit of an edge source is cleared, irq_req = 0, in_service = 1, and the state is SERVICE.
  - If withdraw and grant coincide, the grant wins.
- State SERVICE: in_service = 1. New requests keep latching but are not arbitrated. On irq_reti: in_service = 0 and go to IDLE. Re-arbitration can raise irq_req 1 cycle after that.
- irq_grant outside REQ and irq_reti outside SERVICE are ignored.
- rst asserted mid-handshake forces IDLE and clears everything on the next edge. No src_ack is emitted.
- Latency: edge on src_req → irq_req high after 2 clocks (1 to latch pending, 1 to arbitrate). irq_grant → src_ack after 1 clock.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding IRQ_IDLE / IRQ_REQ / IRQ_SERVICE;
  - source indices SRC_EXT=0, SRC_T0=1, SRC_T1=2;
  - vector constants 10'h010 / 10'h020 / 10'h030.
- One natural sub-module: irq_prio_enc. It is a combinational fixed-priority encoder (NUM_SRC → index + valid) and is reusable by other arbiters.

Test Plan:
- Single edge: gie=1, src_en=3'b111, pulse src_req[0] for 1 cycle → irq_req high 2 cycles later, irq_vector=10'h010, active_id=0. Grant → src_ack=3'b001 for 1 cycle, in_service=1. Reti → in_service=0, irq_req stays 0.
- Priority: raise src_req[1] and src_req[2] (level) in the same cycle → vector 10'h020. Grant, then reti while src_req[2] is still high → second request with vector 10'h030.
- Frozen select: src_req[2] high, reach REQ (vector 10'h030), then raise an edge on src_req[0] before grant → grant still acks src_ack=3'b100. After reti, the ext request is served at 10'h010.
- Masking and withdraw: src_en=3'b000 with an edge on src_req[0] → no irq_req, pending retained. Set src_en[0]=1 → irq_req. Drop gie before grant → irq_req falls, IDLE.
- Overrun: two src_req[0] edges during SERVICE → overrun=3'b001 and one pending. ovr_clr=3'b001 → overrun=0.
- Reset mid-REQ: rst for 1 cycle while irq_req=1 → all outputs 0, no src_ack. A src_req level held high through reset gives no edge.
